// File: rtl/el2_trace_buf.sv
// Retire trace capture buffer: compacts up to NUM_CH packets per cycle into a
// DEPTH-entry FIFO and drains one per cycle; overflowing groups are dropped whole.
module el2_trace_buf #(
    parameter int DEPTH  = 8,
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*32-1:0]       in_insn,
    input  logic [NUM_CH*32-1:0]       in_addr,
    input  logic [NUM_CH-1:0]          in_exc,
    input  logic [NUM_CH*5-1:0]        in_ecause,
    input  logic [NUM_CH-1:0]          in_intr,
    input  logic [NUM_CH*32-1:0]       in_tval,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_insn,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_tval,
    output logic                       out_exc,
    output logic                       out_intr,
    output logic [4:0]                 out_ecause,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic [31:0] tval;
        logic [4:0]  ecause;
        logic        exc;
        logic        intr;
        logic        ovf;
    } pkt_t;

    pkt_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pending_ovf;

    logic [NUM_CH:0][CW-1:0]   off;
    pkt_t [NUM_CH-1:0]         lane_pkt;
    logic [NUM_CH-1:0][PW-1:0] lane_addr;

    // off[i] = number of valid channels older than i, i.e. the compacted slot offset
    assign off[0] = '0;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign off[i+1]     = off[i] + CW'(in_valid[i]);
        assign lane_addr[i] = wr_ptr + off[i][PW-1:0];
        assign lane_pkt[i]  = '{insn:   in_insn[i*32 +: 32],
                                addr:   in_addr[i*32 +: 32],
                                tval:   in_tval[i*32 +: 32],
                                ecause: in_ecause[i*5 +: 5],
                                exc:    in_exc[i],
                                intr:   in_intr[i],
                                ovf:    pending_ovf && (off[i] == '0)};
    end

    logic [CW-1:0]  nv;
    logic [CW-1:0]  free;
    logic           push_req;
    logic           accept;
    logic           drop;
    logic           pop;
    logic [CNT_W:0] drop_sum;

    // Space check uses the registered count, so a same-cycle pop never makes room
    assign nv        = (enable && !flush) ? off[NUM_CH] : '0;
    assign free      = CW'(DEPTH) - count;
    assign push_req  = (nv != '0);
    assign accept    = push_req && (nv <= free);
    assign drop      = push_req && (nv > free);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(nv);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pending_ovf <= 1'b0;
            drop_cnt    <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pending_ovf <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (accept) begin
                wr_ptr      <= wr_ptr + PW'(nv);
                pending_ovf <= 1'b0;
            end
            if (drop) begin
                pending_ovf <= 1'b1;
                drop_cnt    <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (accept ? nv : '0) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (accept && in_valid[i])
                mem[lane_addr[i]] <= lane_pkt[i];
    end

    // Storage is not reset, so the head is gated to read zero while empty
    pkt_t head;
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_insn   = head.insn;
    assign out_addr   = head.addr;
    assign out_tval   = head.tval;
    assign out_ecause = head.ecause;
    assign out_exc    = head.exc;
    assign out_intr   = head.intr;
    assign out_ovf    = head.ovf;

    a_count_max: assert property (@(posedge clk) disable iff (!rst_l) count <= CW'(DEPTH));
    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_l) pop |-> (count != '0));

endmodule
